// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one W-bit shifter between two requesters, with a tagged one-entry result register.
// Define SHARB_STATS_EN to build saturating per-port grant counters; otherwise gnt_cnt0/gnt_cnt1 read zero.
module shift_unit_arbiter #(
  parameter int W     = 32,
  parameter int CNT_W = 16,
  localparam int SW   = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic [SW-1:0]    req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  input  logic [SW-1:0]    req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} t_state;

  function automatic logic [W-1:0] f_shift(input logic [W-1:0] data,
                                           input logic [SW-1:0] shamt,
                                           input logic [1:0] op);
    logic [W-1:0] res;
    case (op)
      2'b00:   res = data >> shamt;
      2'b01:   res = $signed(data) >>> shamt;
      2'b10:   res = data << shamt;
      2'b11:   res = data;
      default: res = data;
    endcase
    return res;
  endfunction

  t_state         r_state;
  logic           r_res_valid;
  logic [W-1:0]   r_res_data;
  logic           r_res_id;
  logic           r_last_gnt;

  logic           w_can_accept;
  logic           w_gnt;
  logic           w_acc0;
  logic           w_acc1;
  logic           w_accept;
  logic [W-1:0]   w_sel_data;
  logic [SW-1:0]  w_sel_shamt;
  logic [1:0]     w_sel_op;

  assign w_can_accept = !r_res_valid || res_ready;

  // Grant select: a lone requester wins, contention goes to the port not granted last.
  always_comb begin
    w_gnt = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last_gnt;
      default: w_gnt = 1'b0;
    endcase
  end

  assign req0_ready = w_can_accept && (w_gnt == 1'b0);
  assign req1_ready = w_can_accept && (w_gnt == 1'b1);
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_accept   = w_acc0 || w_acc1;

  // Operand mux feeding the single shared shifter.
  always_comb begin
    w_sel_data  = req0_data;
    w_sel_shamt = req0_shamt;
    w_sel_op    = req0_op;
    if (w_gnt) begin
      w_sel_data  = req1_data;
      w_sel_shamt = req1_shamt;
      w_sel_op    = req1_op;
    end else begin
      w_sel_data  = req0_data;
      w_sel_shamt = req0_shamt;
      w_sel_op    = req0_op;
    end
  end

  // Result slot FSM: a back-to-back accept reloads the slot while the old result drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_res_valid <= 1'b0;
      r_res_data  <= {W{1'b0}};
      r_res_id    <= 1'b0;
      r_last_gnt  <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_FULL;
            r_res_valid <= 1'b1;
            r_res_data  <= f_shift(w_sel_data, w_sel_shamt, w_sel_op);
            r_res_id    <= w_gnt;
            r_last_gnt  <= w_gnt;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_state     <= S_FULL;
            r_res_valid <= 1'b1;
            r_res_data  <= f_shift(w_sel_data, w_sel_shamt, w_sel_op);
            r_res_id    <= w_gnt;
            r_last_gnt  <= w_gnt;
          end else if (res_ready) begin
            r_state     <= S_EMPTY;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

`ifdef SHARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_gnt_cnt0;
  logic [CNT_W-1:0] r_gnt_cnt1;

  // Saturating grant counters, one per port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= {CNT_W{1'b0}};
      r_gnt_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_acc0 && (r_gnt_cnt0 != CNT_MAX)) begin
        r_gnt_cnt0 <= r_gnt_cnt0 + CNT_ONE;
      end
      if (w_acc1 && (r_gnt_cnt1 != CNT_MAX)) begin
        r_gnt_cnt1 <= r_gnt_cnt1 + CNT_ONE;
      end
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`else
  assign gnt_cnt0 = {CNT_W{1'b0}};
  assign gnt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: a transaction-level model predicts grants and results,
// a separate monitor pops expected results whenever the DUT presents one.
module tb_shift_unit_arbiter;

  localparam logic [1:0] OP_SRL  = 2'd0;
  localparam logic [1:0] OP_SRA  = 2'd1;
  localparam logic [1:0] OP_SLL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
  logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_id;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  shift_unit_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic        id_log[$];
  logic [31:0] data_log[$];

  logic m_valid = 1'b0;
  logic m_last  = 1'b1;
  int   m_cnt0  = 0;
  int   m_cnt1  = 0;
  logic acc0, acc1;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] op);
    logic [31:0] r;
    r = d;
    case (op)
      OP_SRL: r = d >> sh;
      OP_SRA: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? d[i + sh] : d[31];
      OP_SLL: r = d << sh;
      default: r = d;
    endcase
    return r;
  endfunction

  // Model one cycle of arbitration from the inputs now on the pins; the edge that follows commits it.
  task automatic model_step();
    logic can, win;
    can = !m_valid || res_ready;
    if (req0_valid && req1_valid) win = ~m_last;
    else win = req1_valid;
    acc0 = !rst && can && req0_valid && !win;
    acc1 = !rst && can && req1_valid && win;
    if (req0_valid) check("req0_ready", {32'd0, req0_ready}, {32'd0, acc0});
    if (req1_valid) check("req1_ready", {32'd0, req1_ready}, {32'd0, acc1});
    if (acc0) begin
      exp_q.push_back({1'b0, ref_shift(req0_data, req0_shamt, req0_op)});
      m_last = 1'b0; m_valid = 1'b1; m_cnt0++;
    end else if (acc1) begin
      exp_q.push_back({1'b1, ref_shift(req1_data, req1_shamt, req1_op)});
      m_last = 1'b1; m_valid = 1'b1; m_cnt1++;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic v0, input logic [31:0] d0, input logic [4:0] s0, input logic [1:0] o0,
                     input logic v1, input logic [31:0] d1, input logic [4:0] s1, input logic [1:0] o1,
                     input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_data = d0; req0_shamt = s0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_shamt = s1; req1_op = o1;
    res_ready = rr;
    #1;
    model_step();
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 32'd0, 5'd0, OP_SRL, 1'b0, 32'd0, 5'd0, OP_SRL, rr);
  endtask

  // Monitor: pop on each new result, then require it to stay put until consumed.
  logic        seen = 1'b0;
  logic [32:0] held;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (res_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_result: got id=%0d data=%h, expected none", res_id, res_data);
          end else begin
            held = exp_q.pop_front();
            check("result", {res_id, res_data}, held);
          end
          held = {res_id, res_data};
          id_log.push_back(res_id);
          data_log.push_back(res_data);
          seen = 1'b1;
        end else begin
          check("hold_stable", {res_id, res_data}, held);
        end
        if (res_ready) seen = 1'b0;
      end
    end
  end

  int base;
  int budget;
  logic p0v, p1v;
  logic [31:0] p0d, p1d;
  logic [4:0]  p0s, p1s;
  logic [1:0]  p0o, p1o;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {res_valid, res_id, res_data}, 34'd0);
    check("rst_cnt", {1'b0, gnt_cnt0, gnt_cnt1}, 33'd0);
    @(posedge clk); #1 rst = 1'b0;

    cyc(1'b1, 32'hC000_0000, 5'd3, OP_SRA, 1'b0, 32'd0, 5'd0, OP_SRL, 1'b1);
    idle(1'b1);
    check("sra_neg", {res_valid, res_id, res_data}, {1'b1, 1'b0, 32'hF800_0000});

    cyc(1'b0, 32'd0, 5'd0, OP_SRL, 1'b1, 32'h4000_0001, 5'd4, OP_SRL, 1'b1);
    cyc(1'b0, 32'd0, 5'd0, OP_SRL, 1'b1, 32'h4000_0001, 5'd4, OP_SRA, 1'b1);
    check("srl_p1", {res_id, res_data}, {1'b1, 32'h0400_0000});
    idle(1'b1);
    check("sra_pos", {res_id, res_data}, {1'b1, 32'h0400_0000});

    cyc(1'b1, 32'h8000_0000, 5'd31, OP_SRA, 1'b0, 32'd0, 5'd0, OP_SRL, 1'b1);
    cyc(1'b0, 32'd0, 5'd0, OP_SRL, 1'b1, 32'h1234_5678, 5'd0, OP_SLL, 1'b1);
    check("sra_31", res_data, 32'hFFFF_FFFF);
    idle(1'b1);
    check("shamt0", res_data, 32'h1234_5678);
    idle(1'b1);

    base = id_log.size();
    repeat (4) cyc(1'b1, 32'h0000_0001, 5'd31, OP_SLL, 1'b1, 32'hDEAD_BEEF, 5'd7, OP_PASS, 1'b1);
    idle(1'b1); idle(1'b1);
    if (id_log.size() < base + 4) check("alt_count", id_log.size(), base + 4);
    else for (int k = 0; k < 4; k++) begin
      check("alt_id", id_log[base + k], k % 2);
      check("alt_data", data_log[base + k], (k % 2 == 0) ? 32'h8000_0000 : 32'hDEAD_BEEF);
    end

    cyc(1'b1, 32'h0000_00F0, 5'd4, OP_SRL, 1'b1, 32'hF000_0000, 5'd2, OP_SRA, 1'b1);
    repeat (3) begin
      cyc(1'b1, 32'h0000_00F0, 5'd4, OP_SRL, 1'b1, 32'hF000_0000, 5'd2, OP_SRA, 1'b0);
      check("stall_ready", {req0_ready, req1_ready}, 2'b00);
    end
    cyc(1'b1, 32'h0000_00F0, 5'd4, OP_SRL, 1'b1, 32'hF000_0000, 5'd2, OP_SRA, 1'b1);
    check("resume_ready1", req1_ready, 1'b1);
    cyc(1'b1, 32'h0000_00F0, 5'd4, OP_SRL, 1'b1, 32'hF000_0000, 5'd2, OP_SRA, 1'b0);

    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("async_rst", {res_valid, res_id, res_data}, 34'd0);
    exp_q.delete(); m_valid = 1'b0; m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    @(posedge clk); #1 rst = 1'b0; res_ready = 1'b1;
    #1;
    model_step();
    check("first_after_rst", {req0_ready, req1_ready}, 2'b10);

    p0v = 1'b0; p1v = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(p0v && !acc0)) begin
        p0v = ($urandom_range(0, 9) < 7); p0d = $urandom; p0s = 5'($urandom); p0o = 2'($urandom);
      end
      if (!(p1v && !acc1)) begin
        p1v = ($urandom_range(0, 9) < 7); p1d = $urandom; p1s = 5'($urandom); p1o = 2'($urandom);
      end
      cyc(p0v, p0d, p0s, p0o, p1v, p1d, p1s, p1o, ($urandom_range(0, 3) != 0));
    end

    budget = 0;
    do begin
      idle(1'b1);
      budget++;
    end while ((exp_q.size() != 0 || res_valid) && budget < 20);
    if (budget >= 20) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);

`ifdef SHARB_STATS_EN
    check("gnt_cnt0", gnt_cnt0, (m_cnt0 > 65535) ? 65535 : m_cnt0);
    check("gnt_cnt1", gnt_cnt1, (m_cnt1 > 65535) ? 65535 : m_cnt1);
`else
    check("gnt_cnt0_tied", gnt_cnt0, 16'd0);
    check("gnt_cnt1_tied", gnt_cnt1, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
